// File: rtl/alu16_rr_sched.sv
// alu16_rr_sched: round-robin arbiter feeding one shared registered 16-bit ALU.
// Optional completed-op counter built only with `ALU16_SCHED_PERF_EN.
module alu16_rr_sched #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  input  logic [NREQ*4-1:0]  req_s,
  output logic               alu_en,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  output logic [3:0]         alu_s,
  input  logic [15:0]        alu_yout,
  input  logic               alu_carry,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_y,
  output logic               rsp_carry,
  output logic               busy,
  output logic [15:0]        perf_ops
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] op_id;
  logic [15:0]    op_a;
  logic [15:0]    op_b;
  logic [3:0]     op_s;

  logic           found;
  logic           grant;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   idx;

  // Scan starting at rr_ptr; one extra bit lets the sum wrap mod NREQ.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = idx[IDW-1:0];
      end
    end
  end

  assign grant     = (state == IDLE) && found;
  assign req_ready = grant ? (NREQ'(1) << win_id) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      op_id  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_s   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_a  <= req_a[16*win_id +: 16];
            op_b  <= req_b[16*win_id +: 16];
            op_s  <= req_s[4*win_id +: 4];
            op_id <= win_id;
            state <= EXEC;
          end
        end
        EXEC: state <= RESP;
        RESP: begin
          if (rsp_ready) begin
            rr_ptr <= (op_id == IDW'(NREQ-1))
                    ? '0 : op_id + IDW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_en    = (state == EXEC);
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_s     = op_s;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = op_id;
  assign rsp_y     = rsp_valid ? alu_yout : '0;
  assign rsp_carry = rsp_valid & alu_carry;
  assign busy      = (state != IDLE);

`ifdef ALU16_SCHED_PERF_EN
  logic [15:0] ops_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ops_q <= '0;
    else if (rsp_valid && rsp_ready)
      ops_q <= ops_q + 16'd1;
  end

  assign perf_ops = ops_q;
`else
  assign perf_ops = 16'h0000;
`endif

endmodule

// File: tb/tb_alu16_rr_sched.sv
// tb_alu16_rr_sched: directed vectors and handshake corner cases
// for alu16_rr_sched, with an enabled registered ALU model.
module tb_alu16_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] req_s;
  logic        alu_en;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_s;
  logic [15:0] alu_yout;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_y;
  logic        rsp_carry;
  logic        busy;
  logic [15:0] perf_ops;

  int checks  = 0;
  int errors  = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  alu16_rr_sched #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_s     (req_s),
    .alu_en    (alu_en),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_yout  (alu_yout),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_carry (rsp_carry),
    .busy      (busy),
    .perf_ops  (perf_ops)
  );

  // ALU core model: 0 add, 1 sub (carry=borrow), 2 and, 3 or, 4 xor, else pass a
  function automatic logic [16:0] alu_f(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [3:0]  s);
    case (s)
      4'h0:    return {1'b0, a} + {1'b0, b};
      4'h1:    return {1'b0, a} - {1'b0, b};
      4'h2:    return {1'b0, a & b};
      4'h3:    return {1'b0, a | b};
      4'h4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n)
      {alu_carry, alu_yout} <= '0;
    else if (alu_en)
      {alu_carry, alu_yout} <= alu_f(alu_a, alu_b, alu_s);
  end

  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  gid;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic [15:0] y;
    logic        c;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [3:0]  s);
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_s[4*i +: 4]   = s;
    end
  endtask

  // One full op from IDLE: grant, EXEC, RESP with rsp_ready high.
  task automatic do_op(input logic [3:0]  mask,
                       input logic [1:0]  gid,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [3:0]  s,
                       input logic [15:0] y,
                       input logic        c);
    logic [3:0] onehot;
    onehot = 4'b0001 << gid;
    set_ops(a, b, s);
    req_valid = mask;
    rsp_ready = 1'b1;
    #1;
    chk("grant", {28'd0, req_ready}, {28'd0, onehot});
    chk("idle_busy", {31'd0, busy}, 32'd0);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("exec_en", {31'd0, alu_en}, 32'd1);
    chk("exec_a", {16'd0, alu_a}, {16'd0, a});
    chk("exec_b", {16'd0, alu_b}, {16'd0, b});
    chk("exec_s", {28'd0, alu_s}, {28'd0, s});
    chk("exec_ready", {28'd0, req_ready}, 32'd0);
    tick();
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_id", {30'd0, rsp_id}, {30'd0, gid});
    chk("rsp_y", {16'd0, rsp_y}, {16'd0, y});
    chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, c});
    chk("rsp_en", {31'd0, alu_en}, 32'd0);
    tick();
    exp_ops++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4'b0001, 2'd0, 16'h1234, 16'h0F0F, 4'h0, 16'h2143, 1'b0};
    tbl[1] = '{4'b0010, 2'd1, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 1'b1};
    tbl[2] = '{4'b0100, 2'd2, 16'h0005, 16'h0007, 4'h1, 16'hFFFE, 1'b1};
    tbl[3] = '{4'b1000, 2'd3, 16'hF0F0, 16'h0FF0, 4'h2, 16'h00F0, 1'b0};
    tbl[4] = '{4'b0001, 2'd0, 16'hF0F0, 16'h0FF0, 4'h3, 16'hFFF0, 1'b0};
    tbl[5] = '{4'b0010, 2'd1, 16'hAAAA, 16'h5555, 4'h4, 16'hFFFF, 1'b0};
    tbl[6] = '{4'b0100, 2'd2, 16'h8000, 16'h8000, 4'h0, 16'h0000, 1'b1};
    tbl[7] = '{4'b1000, 2'd3, 16'h1234, 16'h9999, 4'hF, 16'h1234, 1'b0};

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_s     = '0;
    tick();
    tick();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_en", {31'd0, alu_en}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_rsp_y", {16'd0, rsp_y}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_perf", {16'd0, perf_ops}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].mask, tbl[i].gid, tbl[i].a, tbl[i].b,
            tbl[i].s, tbl[i].y, tbl[i].c);

    // All four requesting, response always accepted: rotation 0,1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'(i + 1);
      req_b[16*i +: 16] = 16'h0010;
      req_s[4*i +: 4]   = 4'h0;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 15; k++) begin
      logic [1:0] g;
      g = 2'((k / 3) % 4);
      case (k % 3)
        0: begin
          chk("rr_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << g});
          chk("rr_en0", {31'd0, alu_en}, 32'd0);
        end
        1: begin
          chk("rr_ready1", {28'd0, req_ready}, 32'd0);
          chk("rr_en1", {31'd0, alu_en}, 32'd1);
          chk("rr_alu_a", {16'd0, alu_a}, {30'd0, g} + 32'd1);
        end
        default: begin
          chk("rr_ready2", {28'd0, req_ready}, 32'd0);
          chk("rr_en2", {31'd0, alu_en}, 32'd0);
          chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
          chk("rr_id", {30'd0, rsp_id}, {30'd0, g});
          chk("rr_y", {16'd0, rsp_y}, {30'd0, g} + 32'h11);
          exp_ops++;
        end
      endcase
      tick();
    end
    req_valid = 4'b0000;

    // Pointer now 1: grant 3, pointer wraps to 0, lone requester 2 wins.
    do_op(4'b1000, 2'd3, 16'h0003, 16'h0004, 4'h0, 16'h0007, 1'b0);
    do_op(4'b0100, 2'd2, 16'h00FF, 16'h0F0F, 4'h4, 16'h0FF0, 1'b0);

    // Pointer 3: grant id 1, then stall the response with all requesting.
    set_ops(16'h0102, 16'h0304, 4'h0);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("stall_grant", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("stall_exec_en", {31'd0, alu_en}, 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_id", {30'd0, rsp_id}, 32'd1);
      chk("stall_y", {16'd0, rsp_y}, 32'h0406);
      chk("stall_ready", {28'd0, req_ready}, 32'd0);
      chk("stall_en", {31'd0, alu_en}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("stall_last_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    exp_ops++;
    chk("stall_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stall_done_busy", {31'd0, busy}, 32'd0);
    chk("stall_next_grant", {28'd0, req_ready}, 32'h4);

    // Reset while the id 2 op sits in EXEC.
    tick();
    chk("pre_rst_en", {31'd0, alu_en}, 32'd1);
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    tick();
    exp_ops = 0;
    chk("mid_rst_en", {31'd0, alu_en}, 32'd0);
    chk("mid_rst_a", {16'd0, alu_a}, 32'd0);
    chk("mid_rst_b", {16'd0, alu_b}, 32'd0);
    chk("mid_rst_s", {28'd0, alu_s}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_id", {30'd0, rsp_id}, 32'd0);
    chk("mid_rst_y", {16'd0, rsp_y}, 32'd0);
    chk("mid_rst_carry", {31'd0, rsp_carry}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_perf", {16'd0, perf_ops}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      tick();
    end

    // Ten ops after reset; the first must go to id 0.
    do_op(4'b1111, 2'd0, 16'h0001, 16'h0002, 4'h0, 16'h0003, 1'b0);
    for (int i = 1; i < 10; i++)
      do_op(4'b0001 << (i % 4), 2'(i % 4), 16'(i), 16'(i),
            4'h0, 16'(2 * i), 1'b0);
`ifdef ALU16_SCHED_PERF_EN
    chk("perf_ops", {16'd0, perf_ops}, exp_ops);
`else
    chk("perf_ops", {16'd0, perf_ops}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
